// File: rtl/p_ddr.sv
// Shared DDR definitions: one-hot FSM encodings, client IDs and default widths.
package p_ddr;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ISSUE = 3'b010,
        ST_DATA  = 3'b100
    } state_t;

    localparam logic CLI_DISP  = 1'b0;
    localparam logic CLI_RECOG = 1'b1;

endpackage

// File: rtl/ddr_rd_arb_pick.sv
// Two-client priority picker: display wins unless the recognition client has
// been passed over STARVE_MAX times in a row.
module ddr_rd_arb_pick
    import p_ddr::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic ddr_clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_c0_req,
    input  logic i_c1_req,
    output logic o_grant,
    output logic o_gnt_id
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] r_starve;
    logic          w_starved;

    assign w_starved = (r_starve == SW'(STARVE_MAX));
    assign o_grant   = i_en & (i_c0_req | i_c1_req);
    assign o_gnt_id  = (i_c1_req & (~i_c0_req | w_starved)) ? CLI_RECOG : CLI_DISP;

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (o_grant) begin
            // a display grant while recognition waits counts toward starvation
            if (o_gnt_id == CLI_RECOG || !i_c1_req)
                r_starve <= '0;
            else if (!w_starved)
                r_starve <= r_starve + SW'(1);
        end
    end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Two-client DDR read-port arbiter: one burst in flight, beats steered to owner.
// Optional watchdog enabled by defining DDR_RD_ARB_TIMEOUT_EN.
module ddr_rd_arbiter
    import p_ddr::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEN_W      = 4,
    parameter int STARVE_MAX = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic              ddr_clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic [ADDR_W-1:0] c0_adr,
    input  logic [LEN_W-1:0]  c0_len,
    output logic              c0_ack,
    output logic              c0_rvalid,
    output logic              c0_done,
    input  logic              c1_req,
    input  logic [ADDR_W-1:0] c1_adr,
    input  logic [LEN_W-1:0]  c1_len,
    output logic              c1_ack,
    output logic              c1_rvalid,
    output logic              c1_done,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_req,
    output logic [ADDR_W-1:0] ddr_rd_adr,
    output logic [LEN_W-1:0]  arlen,
    input  logic [DATA_W-1:0] ddr_rdata,
    input  logic              rdata_valid,
    input  logic              ddr_rbusy,
    output logic              err_timeout
);

    state_t            r_state, w_next;
    logic              r_gnt_id;
    logic [ADDR_W-1:0] r_adr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat;
    logic              r_ack0, r_ack1, r_done0, r_done1;
    logic              w_grant, w_pick_id, w_busy, w_fin, w_to;

    ddr_rd_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .ddr_clk  (ddr_clk),
        .rst      (rst),
        .i_en     ((r_state == ST_IDLE) & ~ddr_rbusy),
        .i_c0_req (c0_req),
        .i_c1_req (c1_req),
        .o_grant  (w_grant),
        .o_gnt_id (w_pick_id)
    );

    assign w_busy = (r_state == ST_ISSUE) | (r_state == ST_DATA);
    assign w_fin  = rdata_valid & (((r_state == ST_ISSUE) & (r_len == '0)) |
                                   ((r_state == ST_DATA)  & (r_beat == r_len)));

`ifdef DDR_RD_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wdog;
    logic            r_err;

    assign w_to        = w_busy & ~rdata_valid & (r_wdog == WD_W'(TIMEOUT - 1));
    assign err_timeout = r_err;

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_grant || rdata_valid)
                r_wdog <= '0;
            else if (w_busy)
                r_wdog <= r_wdog + WD_W'(1);
            if (w_to)
                r_err <= 1'b1;
        end
    end
`else
    assign w_to        = 1'b0;
    // constant 0: TIMEOUT only matters when the watchdog is built in
    assign err_timeout = (TIMEOUT < 0);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant) w_next = ST_ISSUE;
            ST_ISSUE: if (rdata_valid) w_next = (r_len == '0) ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_fin) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (w_to)
            w_next = ST_IDLE;
    end

    always_ff @(posedge ddr_clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            r_gnt_id <= CLI_DISP;
            r_adr    <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
        end else begin
            r_ack0  <= w_grant & (w_pick_id == CLI_DISP);
            r_ack1  <= w_grant & (w_pick_id == CLI_RECOG);
            r_done0 <= (w_fin | w_to) & (r_gnt_id == CLI_DISP);
            r_done1 <= (w_fin | w_to) & (r_gnt_id == CLI_RECOG);
            if (w_grant) begin
                r_gnt_id <= w_pick_id;
                r_adr    <= (w_pick_id == CLI_RECOG) ? c1_adr : c0_adr;
                r_len    <= (w_pick_id == CLI_RECOG) ? c1_len : c0_len;
            end
            // beat 0 arrives in ISSUE; DATA counts the rest up to arlen
            if (rdata_valid && r_state == ST_ISSUE)
                r_beat <= LEN_W'(1);
            else if (rdata_valid && r_state == ST_DATA)
                r_beat <= r_beat + LEN_W'(1);
        end
    end

    assign rd_req     = (r_state == ST_ISSUE);
    assign ddr_rd_adr = r_adr;
    assign arlen      = r_len;
    assign c0_ack     = r_ack0;
    assign c1_ack     = r_ack1;
    assign c0_done    = r_done0;
    assign c1_done    = r_done1;
    assign c0_rvalid  = rdata_valid & w_busy & (r_gnt_id == CLI_DISP);
    assign c1_rvalid  = rdata_valid & w_busy & (r_gnt_id == CLI_RECOG);
    assign rdata      = ddr_rdata;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Bench for ddr_rd_arbiter: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_ddr_rd_arbiter;

    localparam int AW   = 28;
    localparam int DW   = 256;
    localparam int LW   = 4;
    localparam int SMAX = 8;
    localparam int TO   = 16;

    logic          ddr_clk = 1'b0;
    logic          rst = 1'b1;
    logic          c0_req = 1'b0, c1_req = 1'b0;
    logic [AW-1:0] c0_adr = '0, c1_adr = '0;
    logic [LW-1:0] c0_len = '0, c1_len = '0;
    logic          c0_ack, c0_rvalid, c0_done, c1_ack, c1_rvalid, c1_done;
    logic [DW-1:0] rdata, ddr_rdata = '0;
    logic          rd_req, rdata_valid = 1'b0, ddr_rbusy = 1'b0, err_timeout;
    logic [AW-1:0] ddr_rd_adr;
    logic [LW-1:0] arlen;

    always #5 ddr_clk = ~ddr_clk;

    ddr_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .STARVE_MAX(SMAX), .TIMEOUT(TO)) dut (
        .ddr_clk(ddr_clk), .rst(rst),
        .c0_req(c0_req), .c0_adr(c0_adr), .c0_len(c0_len),
        .c0_ack(c0_ack), .c0_rvalid(c0_rvalid), .c0_done(c0_done),
        .c1_req(c1_req), .c1_adr(c1_adr), .c1_len(c1_len),
        .c1_ack(c1_ack), .c1_rvalid(c1_rvalid), .c1_done(c1_done),
        .rdata(rdata), .rd_req(rd_req), .ddr_rd_adr(ddr_rd_adr), .arlen(arlen),
        .ddr_rdata(ddr_rdata), .rdata_valid(rdata_valid), .ddr_rbusy(ddr_rbusy),
        .err_timeout(err_timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one outstanding burst, counted down in remaining beats.
    bit          m_active, m_owner, m_ack0, m_ack1, m_done0, m_done1, m_rdreq, m_err, p1;
    int          m_left, m_starve, m_idle;
    logic [AW-1:0] m_adr;
    logic [LW-1:0] m_len;

    // Inputs seen at a negedge are those the DUT sampled on the preceding posedge.
    initial forever begin
        @(negedge ddr_clk);
        if (rst) begin
            m_active = 0; m_owner = 0; m_ack0 = 0; m_ack1 = 0; m_done0 = 0; m_done1 = 0;
            m_rdreq = 0; m_err = 0; m_left = 0; m_starve = 0; m_idle = 0; m_adr = '0; m_len = '0;
        end else begin
            m_ack0 = 0; m_ack1 = 0; m_done0 = 0; m_done1 = 0;
            if (!m_active) begin
                if ((c0_req || c1_req) && !ddr_rbusy) begin
                    p1 = c1_req && (!c0_req || m_starve == SMAX);
                    m_owner = p1;
                    m_adr = p1 ? c1_adr : c0_adr;
                    m_len = p1 ? c1_len : c0_len;
                    m_left = int'(m_len) + 1;
                    m_active = 1; m_rdreq = 1; m_idle = 0;
                    if (p1) m_ack1 = 1; else m_ack0 = 1;
                    if (p1 || !c1_req) m_starve = 0;
                    else if (m_starve < SMAX) m_starve++;
                end
            end else if (rdata_valid) begin
                m_left--; m_rdreq = 0; m_idle = 0;
                if (m_left == 0) begin
                    m_active = 0;
                    if (m_owner) m_done1 = 1; else m_done0 = 1;
                end
            end else begin
`ifdef DDR_RD_ARB_TIMEOUT_EN
                m_idle++;
                if (m_idle == TO) begin
                    m_active = 0; m_rdreq = 0; m_err = 1;
                    if (m_owner) m_done1 = 1; else m_done0 = 1;
                end
`endif
            end
        end
        chk("ctl", {56'd0, c0_ack, c1_ack, c0_done, c1_done, c0_rvalid, c1_rvalid, rd_req, err_timeout},
            {56'd0, m_ack0, m_ack1, m_done0, m_done1, rdata_valid && m_active && !m_owner,
             rdata_valid && m_active && m_owner, m_rdreq, m_err});
        chk("adr_len", {32'd0, ddr_rd_adr, arlen}, {32'd0, m_adr, m_len});
        chk("rdata", rdata[63:0] ^ rdata[DW-1:DW-64], ddr_rdata[63:0] ^ ddr_rdata[DW-1:DW-64]);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge ddr_clk);
            #1;
        end
    endtask

    task automatic wait_ack(output bit who);
        bit ok = 0;
        who = 0;
        for (int i = 0; i < 40; i++) begin
            if (c0_ack || c1_ack) begin
                who = c1_ack; ok = 1;
                break;
            end
            cyc(1);
        end
        chk("ack_seen", {63'd0, ok}, 64'd1);
    endtask

    task automatic burst(input int beats, input int gap);
        for (int b = 0; b < beats; b++) begin
            rdata_valid = 1'b1;
            ddr_rdata = {8{$urandom}};
            cyc(1);
            rdata_valid = 1'b0;
            cyc(gap);
        end
    endtask

    initial begin
        bit who;
        cyc(2);
        chk("rst_rdreq", {63'd0, rd_req}, 0);
        chk("rst_ack", {62'd0, c0_ack, c1_ack}, 0);
        chk("rst_adr", {36'd0, ddr_rd_adr}, 0);
        rst = 1'b0;

        // single len=3 burst for display
        c0_req = 1; c0_adr = 'h100; c0_len = 3;
        cyc(1);
        chk("t1_ack", {63'd0, c0_ack}, 1);
        chk("t1_rdreq", {63'd0, rd_req}, 1);
        chk("t1_adr", {36'd0, ddr_rd_adr}, 'h100);
        chk("t1_len", {60'd0, arlen}, 3);
        c0_req = 0;
        for (int b = 0; b < 4; b++) begin
            rdata_valid = 1; ddr_rdata = {8{$urandom}};
            #1;
            chk("t1_rv0", {63'd0, c0_rvalid}, 1);
            chk("t1_rv1", {63'd0, c1_rvalid}, 0);
            chk("t1_done_early", {63'd0, c0_done}, 0);
            cyc(1);
        end
        rdata_valid = 0;
        chk("t1_done", {63'd0, c0_done}, 1);
        cyc(1);
        chk("t1_done_pulse", {63'd0, c0_done}, 0);

        // both requesting: 8 display grants then one recognition grant
        c0_req = 1; c1_req = 1; c0_len = 0; c1_len = 0; c0_adr = 'h10; c1_adr = 'h20;
        for (int g = 0; g < 18; g++) begin
            wait_ack(who);
            chk("t2_order", {63'd0, who}, (g % 9 == 8) ? 64'd1 : 64'd0);
            if (g == 17) begin c0_req = 0; c1_req = 0; end
            rdata_valid = 1;
            cyc(1);
            rdata_valid = 0;
        end
        cyc(2);

        // reset in the middle of a recognition burst
        c1_req = 1; c1_adr = 'h200; c1_len = 7;
        wait_ack(who);
        chk("t3_who", {63'd0, who}, 1);
        c1_req = 0;
        burst(2, 0);
        rst = 1; rdata_valid = 1;
        cyc(1);
        chk("t3_rdreq", {63'd0, rd_req}, 0);
        chk("t3_len", {60'd0, arlen}, 0);
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_drop", {62'd0, c0_rvalid, c1_rvalid}, 0);
            cyc(1);
        end
        rdata_valid = 0;
        c0_req = 1; c0_adr = 'h300; c0_len = 1;
        wait_ack(who);
        chk("t3_next_who", {63'd0, who}, 0);
        chk("t3_next_adr", {36'd0, ddr_rd_adr}, 'h300);
        c0_req = 0;
        burst(2, 0);
        cyc(1);

        // read port busy holds off the grant
        ddr_rbusy = 1; c0_req = 1; c0_len = 0; c0_adr = 'h40;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("t4_hold", {62'd0, c0_ack, rd_req}, 0);
        end
        ddr_rbusy = 0;
        cyc(1);
        chk("t4_ack", {63'd0, c0_ack}, 1);
        c0_req = 0;
        burst(1, 0);
        cyc(1);

        // gapped beats: done only after the third
        c0_req = 1; c0_adr = 'h400; c0_len = 2;
        wait_ack(who);
        c0_req = 0;
        for (int b = 0; b < 3; b++) begin
            rdata_valid = 1;
            cyc(1);
            rdata_valid = 0;
            chk("t5_done", {63'd0, c0_done}, (b == 2) ? 64'd1 : 64'd0);
            cyc(4);
        end

`ifdef DDR_RD_ARB_TIMEOUT_EN
        c1_req = 1; c1_adr = 'h500; c1_len = 3;
        wait_ack(who);
        c1_req = 0;
        cyc(15);
        chk("t6_err_early", {63'd0, err_timeout}, 0);
        cyc(1);
        chk("t6_err", {63'd0, err_timeout}, 1);
        chk("t6_done", {63'd0, c1_done}, 1);
        chk("t6_rdreq", {63'd0, rd_req}, 0);
        cyc(3);
        chk("t6_sticky", {63'd0, err_timeout}, 1);
        c0_req = 1; c0_len = 0;
        wait_ack(who);
        chk("t6_c0", {63'd0, who}, 0);
        c0_req = 0;
        burst(1, 0);
        cyc(1);
        chk("t6_sticky2", {63'd0, err_timeout}, 1);
`else
        chk("err_off", {63'd0, err_timeout}, 0);
`endif

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr_rd_arbiter.md
Name: ddr_rd_arbiter

Overview:
- Shares the single DDR read channel (rd_req / ddr_rd_adr / arlen / ddr_rdata / rdata_valid / ddr_rbusy) between two read clients.
- Client 0 is the HDMI display refill path: real-time, high priority. Client 1 is the recognition frame reader: best-effort, with starvation protection.
- Sequences one burst at a time and steers returned beats to the owning client.
- Sits between the client read engines and the DDR controller read port, in the ddr_clk domain.

Parameters:
- ADDR_W, 28, DDR controller address width (CTRL_ADDR_WIDTH).
- DATA_W, 256, read data width (MEM_DQ_WIDTH*8).
- LEN_W, 4, arlen width; beats per burst = arlen+1.
- STARVE_MAX, 8, consecutive client-0 grants allowed while client 1 is pending before client 1 is forced.
- TIMEOUT, 1023, watchdog limit in cycles (optional feature only).

Ports:
- ddr_clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- c0_req  in  1  client 0 request; held with c0_adr/c0_len stable until c0_ack.
- c0_adr  in  ADDR_W  client 0 burst address.
- c0_len  in  LEN_W  client 0 arlen.
- c0_ack  out  1  one-cycle grant pulse.
- c0_rvalid  out  1  beat valid for client 0.
- c0_done  out  1  one-cycle pulse after the last beat.
- c1_req, c1_adr, c1_len, c1_ack, c1_rvalid, c1_done  same as client 0, for client 1.
- rdata  out  DATA_W  ddr_rdata broadcast to both clients.
- rd_req  out  1  DDR read request.
- ddr_rd_adr  out  ADDR_W  DDR burst address.
- arlen  out  LEN_W  DDR burst length.
- ddr_rdata  in  DATA_W  DDR read data.
- rdata_valid  in  1  DDR beat valid.
- ddr_rbusy  in  1  DDR read port busy; no new grant while high.
- err_timeout  out  1  sticky watchdog flag (0 when the optional feature is compiled out).

Behaviour:
- Reset (rst=1 at a ddr_clk edge):
  - State goes to IDLE.
  - rd_req, ddr_rd_adr, arlen, both ack, both rvalid, both done, and err_timeout all go to 0.
  - gnt_id and starve_cnt go to 0.
  - Beats arriving after a mid-burst reset are dropped: the rvalid outputs stay 0 in IDLE.
- IDLE:
  - A grant happens when (c0_req | c1_req) & ~ddr_rbusy.
  - Winner is client 1 if c1_req & (~c0_req | starve_cnt==STARVE_MAX); otherwise client 0.
  - On grant: latch gnt_id, adr and len into ddr_rd_adr/arlen; register cN_ack=1 for exactly the next cycle; go to ISSUE.
  - If ddr_rbusy is high, stay in IDLE regardless of requests.
- ISSUE:
  - rd_req=1; ddr_rd_adr/arlen held.
  - On rdata_valid, the beat counts as beat 0 and rd_req drops on the next edge.
  - If arlen==0: go to IDLE and pulse cN_done. Otherwise go to DATA with beat_cnt=1.
- DATA:
  - rd_req=0. Each rdata_valid increments beat_cnt.
  - On a valid with beat_cnt==arlen: pulse cN_done for one cycle and go to IDLE.
  - Gaps in rdata_valid are allowed.
- Data steering:
  - cN_rvalid = rdata_valid & (state is ISSUE or DATA) & gnt_id==N; combinational, zero latency.
  - rdata = ddr_rdata, combinational.
- Done and back-to-back grants:
  - cN_done is registered: it asserts the cycle after the last beat, together with the return to IDLE.
  - A new grant may occur in that same IDLE cycle, so back-to-back bursts leave one IDLE cycle between them.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_MAX) on each client-0 grant while c1_req=1.
  - Clears on a client-1 grant, and clears when a client-0 grant occurs with c1_req=0.
- Simultaneous requests with starve_cnt<STARVE_MAX: client 0 wins.
- Requests arriving during ISSUE/DATA are ignored until IDLE; no queueing.
- Widths: beat_cnt is LEN_W bits and cannot wrap, because arlen ≤ 2^LEN_W−1.
- An unknown state encoding returns to IDLE.

Optional Feature:
- Macro DDR_RD_ARB_TIMEOUT_EN.
- When defined:
  - A wdog counter clears on entering ISSUE and on every rdata_valid, and increments in ISSUE/DATA.
  - When wdog reaches TIMEOUT: force IDLE, drop rd_req, set err_timeout (sticky until rst), pulse done to the owner. No further beats are steered to that owner.
- When undefined: no counter, err_timeout tied to 0, and the FSM waits indefinitely.

Decomposition:
- Shared package/include (p_ddr): state encodings (IDLE=3'b001, ISSUE=3'b010, DATA=3'b100, one-hot like the other DDR FSMs), client ID constants (CLI_DISP=0, CLI_RECOG=1), and the ADDR_W/DATA_W defaults.
- One sub-module: ddr_rd_arb_pick, a combinational+starve_cnt priority selector producing gnt_id and grant. The FSM, beat counter and steering stay in the top.

Test Plan:
- c0_req with adr=0x100, len=3, rbusy=0: c0_ack pulses 1 cycle; rd_req=1 with ddr_rd_adr=0x100, arlen=3; 4 beats produce c0_rvalid ×4 and c1_rvalid 0; c0_done pulses the cycle after beat 4.
- c0_req and c1_req held continuously, len=0, STARVE_MAX=8: grant order is 8× client 0, then 1× client 1, repeating.
- Grant for client 1, then rst=1 after beat 1 of len=7: all outputs go 0 next edge; the remaining beats produce no rvalid; the next c0_req is granted normally.
- ddr_rbusy=1 for 20 cycles with c0_req high: no ack and no rd_req; ack arrives 1 cycle after rbusy falls.
- Data gaps: len=2 with rdata_valid spaced 5 cycles apart: beat_cnt tracks correctly; done follows only the 3rd beat.
- With DDR_RD_ARB_TIMEOUT_EN defined and TIMEOUT=16: grant c1, never return rdata_valid; at cycle 16 err_timeout=1 (stays 1), c1_done pulses, state is IDLE, and a following c0 request is served.
